// File: rtl/trig_capture_if.sv
// Sample-path bundle for trig_capture: strobe, controls, live/delayed samples and burst output.
// master drives the samples and controls; slave is the capture block.
interface trig_capture_if #(
  parameter int WIDTH = 16
);
  logic                    ena;
  logic                    arm;
  logic                    auto_rearm;
  logic                    force_trig;
  logic                    abort;
  logic signed [WIDTH-1:0] thresh;
  logic signed [WIDTH-1:0] din_live;
  logic signed [WIDTH-1:0] din_dly;
  logic signed [WIDTH-1:0] m_data;
  logic                    m_valid;
  logic                    m_last;
  logic                    busy;
  logic                    triggered;

  modport master (
    output ena, arm, auto_rearm, force_trig, abort, thresh, din_live, din_dly,
    input  m_data, m_valid, m_last, busy, triggered
  );

  modport slave (
    input  ena, arm, auto_rearm, force_trig, abort, thresh, din_live, din_dly,
    output m_data, m_valid, m_last, busy, triggered
  );
endinterface

// File: rtl/trig_capture.sv
// Triggered burst capture: watches the live stream for a rising threshold crossing (or force),
// then emits LEN samples of the PRE_TRIG-delayed stream so each burst carries pre-trigger history.
module trig_capture #(
  parameter int WIDTH    = 16,
  parameter int PRE_TRIG = 64,
  parameter int LEN      = 1024,
  parameter int HOLDOFF  = 16
) (
  input  logic          clk,
  input  logic          rst,
  trig_capture_if.slave cap
);

  localparam int FILL_W = $clog2(PRE_TRIG + 1);
  localparam int SMP_W  = $clog2(LEN + 1);
  localparam int HO_W   = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PRE_TRIG);
  localparam logic [SMP_W-1:0]  SMP_LAST  = SMP_W'(LEN - 1);
  localparam logic [HO_W-1:0]   HO_LAST   = HO_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_HOLDOFF} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [FILL_W-1:0]       r_fill_cnt;
  logic [SMP_W-1:0]        r_smp_cnt;
  logic [HO_W-1:0]         r_ho_cnt;
  logic signed [WIDTH-1:0] r_prev_live;
  logic signed [WIDTH-1:0] r_m_data;
  logic                    r_m_valid;
  logic                    r_m_last;
  logic                    r_triggered;

  logic w_cross;
  logic w_trig;
  logic w_beat;
  logic w_last_beat;
  logic w_ho_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // abort overrides every sample event so a truncated burst never reaches m_last
  always_comb begin
    w_state_nxt = r_state;
    w_cross     = (r_prev_live < cap.thresh) && (cap.din_live >= cap.thresh);
    w_trig      = 1'b0;
    w_beat      = 1'b0;
    w_last_beat = 1'b0;
    w_ho_done   = (HOLDOFF == 0) || (cap.ena && (r_ho_cnt == HO_LAST));
    unique case (r_state)
      S_IDLE: begin
        if (cap.arm) w_state_nxt = S_ARMED;
      end
      S_ARMED: begin
        w_trig = cap.ena && (r_fill_cnt == FILL_FULL) && (cap.force_trig || w_cross) && !cap.abort;
        if (w_trig) w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_beat      = cap.ena && !cap.abort;
        w_last_beat = w_beat && (r_smp_cnt == SMP_LAST);
        if (w_last_beat) w_state_nxt = S_HOLDOFF;
      end
      S_HOLDOFF: begin
        if (w_ho_done) w_state_nxt = cap.auto_rearm ? S_ARMED : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (cap.abort) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fill_cnt  <= '0;
      r_smp_cnt   <= '0;
      r_ho_cnt    <= '0;
      r_prev_live <= '0;
      r_m_data    <= '0;
      r_m_valid   <= 1'b0;
      r_m_last    <= 1'b0;
      r_triggered <= 1'b0;
    end else begin
      if (cap.ena) r_prev_live <= cap.din_live;
      r_triggered <= w_trig;
      r_m_valid   <= w_trig || w_beat;
      r_m_last    <= w_last_beat;
      if (w_trig || w_beat) r_m_data <= cap.din_dly;
      if (cap.abort) begin
        r_fill_cnt <= '0;
        r_smp_cnt  <= '0;
        r_ho_cnt   <= '0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (cap.arm) r_fill_cnt <= '0;
          end
          S_ARMED: begin
            // fill count stays at PRE_TRIG through later bursts so auto-rearm keeps its history
            if (cap.ena && (r_fill_cnt != FILL_FULL)) r_fill_cnt <= r_fill_cnt + FILL_W'(1);
            if (w_trig) r_smp_cnt <= SMP_W'(1);
          end
          S_CAPTURE: begin
            if (w_beat)      r_smp_cnt <= r_smp_cnt + SMP_W'(1);
            if (w_last_beat) r_ho_cnt  <= '0;
          end
          S_HOLDOFF: begin
            if (cap.ena) r_ho_cnt <= r_ho_cnt + HO_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign cap.m_data    = r_m_data;
  assign cap.m_valid   = r_m_valid;
  assign cap.m_last    = r_m_last;
  assign cap.triggered = r_triggered;
  assign cap.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_trig_capture.sv
// Directed bench for trig_capture with PRE_TRIG=4, LEN=8, HOLDOFF=2.
// The bench drives din_dly as din_live-4, standing in for the upstream 4-deep shift register on a ramp.
module tb_trig_capture;

  localparam int WIDTH    = 16;
  localparam int PRE_TRIG = 4;
  localparam int LEN      = 8;
  localparam int HOLDOFF  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  trig_capture_if #(.WIDTH(WIDTH)) bus ();

  trig_capture #(
    .WIDTH   (WIDTH),
    .PRE_TRIG(PRE_TRIG),
    .LEN     (LEN),
    .HOLDOFF (HOLDOFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cap(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic e, input int v);
    bus.ena      = e;
    bus.din_live = 16'(v);
    bus.din_dly  = 16'(v - PRE_TRIG);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] dly_of(input int v);
    logic [15:0] d;
    d = 16'(v - PRE_TRIG);
    return 32'(d);
  endfunction

  // beats 2..LEN after a trigger at live value vt; live moves by step per beat, ena every per clks
  task automatic burst_tail(input int vt, input int step, input int per);
    int v;
    for (int i = 1; i < LEN; i++) begin
      v = vt + step * i;
      for (int j = 1; j < per; j++) begin
        drive(1'b0, v - step);
        check("gap_valid", 32'(bus.m_valid), 32'd0);
        check("gap_trig", 32'(bus.triggered), 32'd0);
      end
      drive(1'b1, v);
      check("beat_valid", 32'(bus.m_valid), 32'd1);
      check("beat_data", 32'($unsigned(bus.m_data)), dly_of(v));
      check("beat_last", 32'(bus.m_last), 32'(i == LEN - 1));
      check("beat_trig", 32'(bus.triggered), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ena = 1'b0; bus.arm = 1'b0; bus.auto_rearm = 1'b0; bus.force_trig = 1'b0;
    bus.abort = 1'b0; bus.thresh = 16'sd10; bus.din_live = '0; bus.din_dly = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.m_valid), 32'd0);
    check("rst_last", 32'(bus.m_last), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_trig", 32'(bus.triggered), 32'd0);
    check("rst_data", 32'($unsigned(bus.m_data)), 32'd0);
    rst = 1'b0;

    // T1: ramp, threshold 10, trigger at live=10 -> burst 6..13, then IDLE after 2 holdoff samples
    bus.arm = 1'b1; drive(1'b0, 0); bus.arm = 1'b0;
    check("t1_busy_armed", 32'(bus.busy), 32'd1);
    for (int v = 0; v < 10; v++) begin
      drive(1'b1, v);
      check("t1_no_early_trig", 32'(bus.triggered), 32'd0);
    end
    drive(1'b1, 10);
    check("t1_trig", 32'(bus.triggered), 32'd1);
    check("t1_first_valid", 32'(bus.m_valid), 32'd1);
    check("t1_first_data", 32'($unsigned(bus.m_data)), 32'd6);
    check("t1_first_last", 32'(bus.m_last), 32'd0);
    burst_tail(10, 1, 1);
    drive(1'b1, 0);
    check("t1_ho_valid", 32'(bus.m_valid), 32'd0);
    check("t1_ho_last", 32'(bus.m_last), 32'd0);
    check("t1_ho_busy", 32'(bus.busy), 32'd1);
    drive(1'b1, 20);
    check("t1_ho_cross_ignored", 32'(bus.triggered), 32'd0);
    check("t1_idle_busy", 32'(bus.busy), 32'd0);

    // T2: crossing before history is full is not accepted; later crossing is. Then abort mid-burst.
    bus.arm = 1'b1; drive(1'b0, 20); bus.arm = 1'b0;
    drive(1'b1, 5);
    drive(1'b1, 15);
    check("t2_unqualified_trig", 32'(bus.triggered), 32'd0);
    check("t2_unqualified_valid", 32'(bus.m_valid), 32'd0);
    drive(1'b1, 3);
    drive(1'b1, 4);
    drive(1'b1, 12);
    check("t2_trig", 32'(bus.triggered), 32'd1);
    check("t2_data0", 32'($unsigned(bus.m_data)), 32'd8);
    drive(1'b1, 13);
    check("t2_data1", 32'($unsigned(bus.m_data)), 32'd9);
    drive(1'b1, 14);
    check("t2_beat3_valid", 32'(bus.m_valid), 32'd1);
    check("t2_data2", 32'($unsigned(bus.m_data)), 32'd10);
    bus.abort = 1'b1; drive(1'b1, 15); bus.abort = 1'b0;
    check("t5_abort_valid", 32'(bus.m_valid), 32'd0);
    check("t5_abort_last", 32'(bus.m_last), 32'd0);
    check("t5_abort_busy", 32'(bus.busy), 32'd0);
    bus.arm = 1'b1; bus.abort = 1'b1; drive(1'b0, 15); bus.arm = 1'b0; bus.abort = 1'b0;
    check("t5_arm_abort_busy", 32'(bus.busy), 32'd0);

    // T3: re-arm after abort, ena every 3rd clk
    bus.arm = 1'b1; drive(1'b0, 15); bus.arm = 1'b0;
    check("t3_busy_armed", 32'(bus.busy), 32'd1);
    for (int v = 0; v < 10; v++) begin
      drive(1'b0, v); drive(1'b0, v); drive(1'b1, v);
    end
    drive(1'b0, 10); drive(1'b0, 10);
    check("t3_pre_trig_valid", 32'(bus.m_valid), 32'd0);
    drive(1'b1, 10);
    check("t3_trig", 32'(bus.triggered), 32'd1);
    check("t3_first_data", 32'($unsigned(bus.m_data)), 32'd6);
    burst_tail(10, 1, 3);
    drive(1'b1, 0);
    check("t3_ho_busy", 32'(bus.busy), 32'd1);
    drive(1'b1, 0);
    check("t3_idle_busy", 32'(bus.busy), 32'd0);

    // T4: force trigger on flat zero input (negative delayed data), auto rearm
    bus.force_trig = 1'b1; bus.auto_rearm = 1'b1;
    bus.arm = 1'b1; drive(1'b0, 0); bus.arm = 1'b0;
    for (int k = 0; k < PRE_TRIG; k++) begin
      drive(1'b1, 0);
      check("t4_force_unqualified", 32'(bus.triggered), 32'd0);
    end
    drive(1'b1, 0);
    check("t4_trig", 32'(bus.triggered), 32'd1);
    check("t4_first_valid", 32'(bus.m_valid), 32'd1);
    check("t4_first_data", 32'($unsigned(bus.m_data)), 32'h0000_FFFC);
    burst_tail(0, 0, 1);
    drive(1'b1, 0);
    check("t4_ho1_trig", 32'(bus.triggered), 32'd0);
    check("t4_ho1_busy", 32'(bus.busy), 32'd1);
    drive(1'b1, 0);
    check("t4_ho2_trig", 32'(bus.triggered), 32'd0);
    check("t4_rearmed_busy", 32'(bus.busy), 32'd1);
    check("t4_ho2_valid", 32'(bus.m_valid), 32'd0);
    drive(1'b1, 0);
    check("t4_retrig", 32'(bus.triggered), 32'd1);
    check("t4_retrig_valid", 32'(bus.m_valid), 32'd1);
    check("t4_retrig_data", 32'($unsigned(bus.m_data)), 32'h0000_FFFC);

    // T6: async reset mid-capture drops outputs before the next edge
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(bus.m_valid), 32'd0);
    check("t6_rst_last", 32'(bus.m_last), 32'd0);
    check("t6_rst_busy", 32'(bus.busy), 32'd0);
    check("t6_rst_trig", 32'(bus.triggered), 32'd0);
    check("t6_rst_data", 32'($unsigned(bus.m_data)), 32'd0);
    bus.force_trig = 1'b0; bus.auto_rearm = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b1, 0);
    drive(1'b1, 20);
    check("t6_idle_cross_trig", 32'(bus.triggered), 32'd0);
    check("t6_idle_busy", 32'(bus.busy), 32'd0);
    check("t6_idle_valid", 32'(bus.m_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
